// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the shift/subtract restoring divider.
//   DivWidth    : default operand/quotient/remainder width
//   DivCntWidth : iteration counter width for the default width
//   div_state_t : divider FSM states (FIX is only reachable in signed builds)
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int unsigned DivWidth    = 8;
   localparam int unsigned DivCntWidth = $clog2(DivWidth);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
// Ports:
//   r_i      : partial remainder before this step
//   q_i      : quotient/dividend shift register before this step
//   d_i      : divisor (unsigned magnitude)
//   r_o      : partial remainder after this step
//   q_o      : shift register after this step, new quotient bit in LSB
//   borrow_o : trial subtraction went negative (quotient bit is 0)
// -----------------------------------------------------------------------------
module div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o,
   output logic             borrow_o
);

   logic [WIDTH:0] trial;

   // Shift the next dividend bit into the remainder and try to subtract.
   // The extra top bit acts as the borrow flag.
   assign trial    = {r_i, q_i[WIDTH-1]} - {1'b0, d_i};
   assign borrow_o = trial[WIDTH];

   always_comb begin
      if (borrow_o) begin
         r_o = {r_i[WIDTH-2:0], q_i[WIDTH-1]};
      end else begin
         r_o = trial[WIDTH-1:0];
      end
      q_o = {q_i[WIDTH-2:0], ~borrow_o};
   end

endmodule

// File: rtl/shift_sub_divider.sv
// -----------------------------------------------------------------------------
// shift_sub_divider
// Sequential restoring divider resolving one quotient bit per clock.
// Load captures the divisor; Execute (level-held) starts a division using Din
// as the dividend in the LOAD cycle. The FSM parks in DONE until Execute drops.
//
// Build option: DIVIDER_SIGNED_EN
//   undefined : unsigned operands, no FIX state, no sign flops
//   defined   : two's complement operands, magnitudes divided, one FIX cycle
//               applies the signs (quotient toward zero, remainder follows the
//               dividend). Divide by zero skips FIX and returns the raw dividend.
//
// Ports:
//   Clk     : clock, all flops on rising edge
//   Reset_n : asynchronous active-low reset
//   Load    : capture Din as divisor (honoured in IDLE and DONE only)
//   Execute : start request, must be released before the next start
//   Din     : divisor on Load, dividend in the LOAD cycle
//   Qval    : quotient register (shifting while busy)
//   Rval    : remainder register (changing while busy)
//   Dval    : divisor register
//   Busy    : high in LOAD, ITER and FIX
//   Done    : high in DONE
//   DivZero : divisor was zero when the division started
// -----------------------------------------------------------------------------
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidth
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Load,
   input  logic             Execute,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Qval,
   output logic [WIDTH-1:0] Rval,
   output logic [WIDTH-1:0] Dval,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] step_r, step_q, step_div;
   logic             step_borrow;
   logic             last_iter;

   assign last_iter = (state_q == ITER) && (cnt_q == LastCnt);

`ifdef DIVIDER_SIGNED_EN
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic             sign_q_q, sign_q_d;
   logic             sign_r_q, sign_r_d;
   logic             din_neg, dval_neg;
   logic [WIDTH-1:0] din_mag, dval_mag;

   assign din_neg  = Din[WIDTH-1];
   assign dval_neg = d_q[WIDTH-1];
   // The most negative value maps onto itself, which is its correct unsigned
   // magnitude, so no special case is needed.
   assign din_mag  = din_neg  ? (~Din + 1'b1) : Din;
   assign dval_mag = dval_neg ? (~d_q + 1'b1) : d_q;
   assign step_div = dmag_q;
`else
   assign step_div = d_q;
`endif

   div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .r_i     (r_q),
      .q_i     (q_q),
      .d_i     (step_div),
      .r_o     (step_r),
      .q_o     (step_q),
      .borrow_o(step_borrow)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (Execute) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = ITER;
         end
         ITER: begin
            if (last_iter) begin
`ifdef DIVIDER_SIGNED_EN
               state_d = dz_q ? DONE : FIX;
`else
               state_d = DONE;
`endif
            end
         end
         FIX: begin
            state_d = DONE;
         end
         DONE: begin
            // No auto-restart: Execute must drop before another run.
            if (!Execute) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state_q)
         LOAD, ITER, FIX: Busy = 1'b1;
         DONE:            Done = 1'b1;
         default:         ;
      endcase
   end

   assign Qval    = q_q;
   assign Rval    = r_q;
   assign Dval    = d_q;
   assign DivZero = dz_q;

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      q_d   = q_q;
      r_d   = r_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      dz_d  = dz_q;
`ifdef DIVIDER_SIGNED_EN
      dmag_d   = dmag_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (Load) begin
               d_d = Din;
            end
         end
         LOAD: begin
            r_d   = '0;
            cnt_d = '0;
            dz_d  = (d_q == '0);
`ifdef DIVIDER_SIGNED_EN
            q_d      = din_mag;
            dmag_d   = dval_mag;
            sign_q_d = din_neg ^ dval_neg;
            sign_r_d = din_neg;
`else
            q_d = Din;
`endif
         end
         ITER: begin
            q_d   = step_q;
            r_d   = step_r;
            cnt_d = cnt_q + 1'b1;
`ifdef DIVIDER_SIGNED_EN
            // Divide by zero skips FIX, so restore the raw dividend here.
            if (last_iter && dz_q && sign_r_q) begin
               r_d = ~step_r + 1'b1;
            end
`endif
         end
         FIX: begin
`ifdef DIVIDER_SIGNED_EN
            if (sign_q_q) begin
               q_d = ~q_q + 1'b1;
            end
            if (sign_r_q) begin
               r_d = ~r_q + 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         q_q   <= '0;
         r_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
         dz_q  <= 1'b0;
      end else begin
         q_q   <= q_d;
         r_q   <= r_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
         dz_q  <= dz_d;
      end
   end

`ifdef DIVIDER_SIGNED_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         dmag_q   <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
      end else begin
         dmag_q   <= dmag_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
      end
   end
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// -----------------------------------------------------------------------------
// tb_shift_sub_divider
// Self-checking bench for shift_sub_divider. Expected results come from plain
// integer division. Latency is counted in clocks from the cycle in which
// Execute is first applied until Done is seen.
// -----------------------------------------------------------------------------
module tb_shift_sub_divider;

   localparam int unsigned W = 8;

   logic         Clk;
   logic         Reset_n;
   logic         Load;
   logic         Execute;
   logic [W-1:0] Din;
   logic [W-1:0] Qval, Rval, Dval;
   logic         Busy, Done, DivZero;

   int total = 0;
   int bad   = 0;

   shift_sub_divider #(
      .WIDTH(W)
   ) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .Load   (Load),
      .Execute(Execute),
      .Din    (Din),
      .Qval   (Qval),
      .Rval   (Rval),
      .Dval   (Dval),
      .Busy   (Busy),
      .Done   (Done),
      .DivZero(DivZero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model straight from the arithmetic definition.
   task automatic model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat);
      dz = (dv == '0);
`ifdef DIVIDER_SIGNED_EN
      if (dv == '0) begin
         q   = '1;
         r   = dd;
         lat = W + 2;
      end else begin
         int sa, sd, qi, ri;
         sa  = int'($signed(dd));
         sd  = int'($signed(dv));
         qi  = sa / sd;
         ri  = sa % sd;
         q   = qi[W-1:0];
         r   = ri[W-1:0];
         lat = W + 3;
      end
`else
      if (dv == '0) begin
         q = '1;
         r = dd;
      end else begin
         q = dd / dv;
         r = dd % dv;
      end
      lat = W + 2;
`endif
   endtask

   // Load divisor, start, wait (bounded) for Done. Optionally keep Execute up.
   task automatic run_div(input logic [W-1:0] dv, input logic [W-1:0] dd, input bit keep,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat);
      @(negedge Clk);
      Load = 1'b1;
      Din  = dv;
      @(negedge Clk);
      Load    = 1'b0;
      Execute = 1'b1;
      Din     = dd;
      lat     = 0;
      do begin
         @(posedge Clk);
         lat++;
         #1;
      end while (!Done && lat < 40);
      q  = Qval;
      r  = Rval;
      dz = DivZero;
      if (!keep) begin
         @(negedge Clk);
         Execute = 1'b0;
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      Load    = 1'b0;
      Execute = 1'b0;
      Din     = '0;
      #12;
      total++;
      if ({Qval, Rval, Dval} !== '0) begin
         bad++;
         $display("FAIL reset_regs: Q=%h R=%h D=%h want 00 00 00", Qval, Rval, Dval);
      end
      total++;
      if ({Busy, Done, DivZero} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: busy/done/dz=%b want 000", {Busy, Done, DivZero});
      end
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic check_one(input string name, input logic [W-1:0] dv, input logic [W-1:0] dd);
      logic [W-1:0] q, r, eq, er;
      logic         dz, edz;
      int           lat, elat;
      model(dd, dv, eq, er, edz, elat);
      run_div(dv, dd, 1'b0, q, r, dz, lat);
      total++;
      if (q !== eq || r !== er || dz !== edz) begin
         bad++;
         $display("FAIL %s: %h/%h got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b",
                  name, dd, dv, q, r, dz, eq, er, edz);
      end
      total++;
      if (lat !== elat) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] q, r;
      logic         dz;
      int           lat;
      check_one("basic_100_7", 8'h07, 8'h64);
      check_one("div_zero", 8'h00, 8'h5A);
      check_one("small_dividend", 8'h09, 8'h03);
      check_one("div_by_one", 8'h01, 8'hFF);
      // Fixed values from the datasheet example, same in both builds.
      run_div(8'h07, 8'h64, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'h0E || r !== 8'h02 || dz !== 1'b0) begin
         bad++;
         $display("FAIL fixed_100_7: Q=%h R=%h dz=%b want 0E 02 0", q, r, dz);
      end
      run_div(8'h00, 8'h5A, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'hFF || r !== 8'h5A || dz !== 1'b1) begin
         bad++;
         $display("FAIL fixed_div_zero: Q=%h R=%h dz=%b want FF 5A 1", q, r, dz);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] dv, dd;
         dd = W'($urandom_range(0, 255));
         dv = (i % 6 == 5) ? '0 : W'($urandom_range(0, 255));
         check_one("random", dv, dd);
      end
   endtask

   task automatic test_load_exec_same();
      logic [W-1:0] eq, er;
      logic         edz;
      int           elat, lat;
      model(8'hC8, 8'h0B, eq, er, edz, elat);
      @(negedge Clk);
      Load    = 1'b1;
      Execute = 1'b1;
      Din     = 8'h0B;
      @(negedge Clk);
      Load = 1'b0;
      Din  = 8'hC8;
      lat  = 1;
      do begin
         @(posedge Clk);
         lat++;
         #1;
      end while (!Done && lat < 40);
      total++;
      if (Qval !== eq || Rval !== er || Dval !== 8'h0B || lat !== elat) begin
         bad++;
         $display("FAIL load_exec_same: Q=%h R=%h D=%h lat=%0d want %h %h 0b %0d",
                  Qval, Rval, Dval, lat, eq, er, elat);
      end
      @(negedge Clk);
      Execute = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] q, r;
      logic         dz;
      int           lat;
      @(negedge Clk);
      Load = 1'b1;
      Din  = 8'h07;
      @(negedge Clk);
      Load    = 1'b0;
      Execute = 1'b1;
      Din     = 8'hC8;
      // Edge 1 -> LOAD, edge 2 -> first ITER cycle, so edge 5 opens the 4th.
      repeat (5) @(posedge Clk);
      #1;
      total++;
      if (Busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: busy=%b want 1", Busy);
      end
      #1;
      Reset_n = 1'b0;
      #1;
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0 ||
          {Qval, Rval, Dval} !== '0) begin
         bad++;
         $display("FAIL mid_reset: busy=%b done=%b dz=%b Q=%h R=%h D=%h want all 0",
                  Busy, Done, DivZero, Qval, Rval, Dval);
      end
      @(negedge Clk);
      Execute = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      check_one("after_reset", 8'h0D, 8'hF1);
      run_div(8'h07, 8'hC8, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'h1C || r !== 8'h04) begin
         bad++;
         $display("FAIL after_reset_fixed: Q=%h R=%h want 1C 04", q, r);
      end
   endtask

   task automatic test_hold_done();
      logic [W-1:0] q, r, eq, er;
      logic         dz, edz;
      int           lat, elat, unstable;
      run_div(8'h05, 8'h2F, 1'b1, q, r, dz, lat);
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk);
         #1;
         if (Done !== 1'b1 || Busy !== 1'b0 || Qval !== q || Rval !== r) unstable++;
      end
      total++;
      if (unstable !== 0) begin
         bad++;
         $display("FAIL hold_done: %0d unstable cycles want 0", unstable);
      end
      // Load in DONE changes only the divisor register.
      @(negedge Clk);
      Load = 1'b1;
      Din  = 8'h33;
      @(negedge Clk);
      Load = 1'b0;
      total++;
      if (Dval !== 8'h33 || Qval !== q || Rval !== r || Done !== 1'b1) begin
         bad++;
         $display("FAIL load_in_done: D=%h Q=%h R=%h done=%b want 33 %h %h 1",
                  Dval, Qval, Rval, Done, q, r);
      end
      Execute = 1'b0;
      @(posedge Clk);
      #1;
      total++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL release_exec: done=%b busy=%b want 0 0", Done, Busy);
      end
      // New run on the loaded divisor; a Load while busy must be ignored.
      model(8'hE5, 8'h33, eq, er, edz, elat);
      @(negedge Clk);
      Execute = 1'b1;
      Din     = 8'hE5;
      repeat (3) @(negedge Clk);
      Load = 1'b1;
      Din  = 8'hAA;
      @(negedge Clk);
      Load = 1'b0;
      total++;
      if (Dval !== 8'h33 || Busy !== 1'b1) begin
         bad++;
         $display("FAIL load_while_busy: D=%h busy=%b want 33 1", Dval, Busy);
      end
      lat = 4;
      while (!Done && lat < 40) begin
         @(posedge Clk);
         lat++;
         #1;
      end
      total++;
      if (Qval !== eq || Rval !== er || lat !== elat) begin
         bad++;
         $display("FAIL restart: Q=%h R=%h lat=%0d want %h %h %0d", Qval, Rval, lat, eq, er, elat);
      end
      @(negedge Clk);
      Execute = 1'b0;
      @(posedge Clk);
      #1;
   endtask

`ifdef DIVIDER_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0] q, r;
      logic         dz;
      int           lat;
      run_div(8'h07, 8'h9C, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'hF2 || r !== 8'hFE || lat !== 11) begin
         bad++;
         $display("FAIL signed_neg_dividend: Q=%h R=%h lat=%0d want F2 FE 11", q, r, lat);
      end
      run_div(8'hF9, 8'h64, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'hF2 || r !== 8'h02 || lat !== 11) begin
         bad++;
         $display("FAIL signed_neg_divisor: Q=%h R=%h lat=%0d want F2 02 11", q, r, lat);
      end
      run_div(8'hFF, 8'h80, 1'b0, q, r, dz, lat);
      total++;
      if (q !== 8'h80 || r !== 8'h00) begin
         bad++;
         $display("FAIL signed_wrap: Q=%h R=%h want 80 00", q, r);
      end
      check_one("signed_zero_neg", 8'h00, 8'hA3);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_load_exec_same();
      test_reset_mid();
      test_hold_done();
`ifdef DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
